// File: rtl/registro_resultado_bk.sv
// -----------------------------------------------------------------------------
// registro_resultado_bk
//
// Registered output stage for the 4-bit Brent-Kung adder/subtractor.
// Captures each adder/subtractor result, derives its {N,Z,C,V} flags and
// buffers it through a 2-entry valid/ready skid buffer. A result is never
// lost or duplicated under backpressure. Also keeps sticky carry/overflow
// flags and a saturating count of accepted operations for the ALU status
// register.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   upstream handshake (in_ready is registered)
//   in_op               0 = add, 1 = subtract
//   in_a, in_b          operands as applied to the adder (b uncomplemented)
//   in_result, in_cb    sum/difference and carry (add) / borrow (subtract)
//   clear_sticky        clears sticky flags and op counter
//   out_valid/out_ready downstream handshake
//   out_result          buffered result
//   out_flags           {N,Z,C,V} belonging to out_result
//   sticky_c, sticky_v  OR of C / V over accepted ops since last clear
//   op_count            saturating count of accepted ops
// -----------------------------------------------------------------------------
module registro_resultado_bk #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_result,
   input  logic             in_cb,
   input  logic             clear_sticky,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [3:0]       out_flags,
   output logic             sticky_c,
   output logic             sticky_v,
   output logic [CNT_W-1:0] op_count
);

   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic [3:0]       flags;   // {N,Z,C,V}
   } entry_t;

   entry_t           in_entry;
   entry_t           main_q;
   entry_t           skid_q;
   logic             main_valid;
   logic             skid_valid;
   logic             ready_q;
   logic             accept;
   logic             pop;
   logic             flag_n;
   logic             flag_z;
   logic             flag_c;
   logic             flag_v;
   logic             a_msb;
   logic             b_msb;
   logic             r_msb;
   logic             sc_q;
   logic             sv_q;
   logic [CNT_W-1:0] cnt_q;

   // ---------------------------------------------------------------------------
   // Flag derivation from the incoming fields
   // ---------------------------------------------------------------------------
   always_comb begin
      a_msb  = in_a[WIDTH-1];
      b_msb  = in_b[WIDTH-1];
      r_msb  = in_result[WIDTH-1];
      flag_n = r_msb;
      flag_z = (in_result == '0);
      // in_cb already carries the right sense for each op (carry / borrow)
      flag_c = in_cb;
      // b is uncomplemented, so subtract overflows when the operand signs
      // differ rather than when they match
      if (in_op)
         flag_v = (a_msb != b_msb) && (r_msb != a_msb);
      else
         flag_v = (a_msb == b_msb) && (r_msb != a_msb);
      in_entry.result = in_result;
      in_entry.flags  = {flag_n, flag_z, flag_c, flag_v};
   end

   assign accept = in_valid && ready_q;
   assign pop    = main_valid && out_ready;

   // ---------------------------------------------------------------------------
   // Two-entry skid buffer. main drives the outputs; skid only fills when main
   // is holding and the consumer stalls. in_ready is registered as the
   // inverse of the next skid state, so a full skid blocks the upstream one
   // cycle later and an accept can never coincide with a skid->main move.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         ready_q    <= 1'b1;
         main_q     <= '0;
         skid_q     <= '0;
      end else begin
         if (!main_valid || pop) begin
            if (skid_valid) begin
               // oldest entry lives in skid; ready_q is 0 so no accept here
               main_q     <= skid_q;
               main_valid <= 1'b1;
               skid_valid <= 1'b0;
               ready_q    <= 1'b1;
            end else if (accept) begin
               main_q     <= in_entry;
               main_valid <= 1'b1;
            end else begin
               main_valid <= 1'b0;
            end
         end else if (accept) begin
            // main is stalled: park the new entry in skid and block upstream
            skid_q     <= in_entry;
            skid_valid <= 1'b1;
            ready_q    <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Sticky flags and saturating op counter. A clear that coincides with an
   // accept restarts the history from that accepted op.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sc_q  <= 1'b0;
         sv_q  <= 1'b0;
         cnt_q <= '0;
      end else if (accept && clear_sticky) begin
         sc_q  <= flag_c;
         sv_q  <= flag_v;
         cnt_q <= CNT_W'(1);
      end else if (accept) begin
         sc_q <= sc_q | flag_c;
         sv_q <= sv_q | flag_v;
         if (cnt_q != '1)
            cnt_q <= cnt_q + CNT_W'(1);
      end else if (clear_sticky) begin
         sc_q  <= 1'b0;
         sv_q  <= 1'b0;
         cnt_q <= '0;
      end
   end

   assign in_ready   = ready_q;
   assign out_valid  = main_valid;
   assign out_result = main_q.result;
   assign out_flags  = main_q.flags;
   assign sticky_c   = sc_q;
   assign sticky_v   = sv_q;
   assign op_count   = cnt_q;

endmodule

// File: tb/tb_registro_resultado_bk.sv
module tb_registro_resultado_bk;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       in_op = 1'b0;
   logic [3:0] in_a = '0;
   logic [3:0] in_b = '0;
   logic [3:0] in_result = '0;
   logic       in_cb = 1'b0;
   logic       clear_sticky = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [3:0] out_result;
   logic [3:0] out_flags;
   logic       sticky_c;
   logic       sticky_v;
   logic [7:0] op_count;

   int total = 0;
   int bad = 0;
   bit rnd_ready = 0;

   // expected {result, N, Z, C, V} per accepted op, oldest first
   bit [7:0] sb_q[$];
   bit       m_sc = 0;
   bit       m_sv = 0;
   int       m_cnt = 0;

   registro_resultado_bk #(.WIDTH(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_result(in_result),
      .in_cb(in_cb), .clear_sticky(clear_sticky), .out_valid(out_valid),
      .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags),
      .sticky_c(sticky_c), .sticky_v(sticky_v), .op_count(op_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic, flags from signed/unsigned ranges
   function automatic bit [7:0] model(input bit op, input bit [3:0] a, input bit [3:0] b);
      int ua, ub, sa, sb, u, s;
      bit [3:0] r;
      bit c, v;
      ua = int'(a); ub = int'(b);
      sa = (ua >= 8) ? ua - 16 : ua;
      sb = (ub >= 8) ? ub - 16 : ub;
      if (op) begin u = ua - ub; s = sa - sb; c = (ua < ub); end
      else    begin u = ua + ub; s = sa + sb; c = (u > 15);  end
      r = 4'(u & 15);
      v = (s > 7) || (s < -8);
      return {r, r[3], (r == 4'd0), c, v};
   endfunction

   // Acceptance side: check status against model, then record what the
   // upcoming edge will accept.
   always @(negedge clk) begin
      bit [7:0] e;
      #2;
      if (!rst_n) begin
         sb_q.delete();
         m_sc = 0; m_sv = 0; m_cnt = 0;
      end else begin
         chk("sticky_c", int'(sticky_c), int'(m_sc));
         chk("sticky_v", int'(sticky_v), int'(m_sv));
         chk("op_count", int'(op_count), m_cnt);
         if (in_valid && in_ready) begin
            e = model(in_op, in_a, in_b);
            sb_q.push_back(e);
            if (clear_sticky) begin m_sc = e[1]; m_sv = e[0]; m_cnt = 1; end
            else begin
               m_sc = m_sc | e[1];
               m_sv = m_sv | e[0];
               if (m_cnt < 255) m_cnt++;
            end
         end else if (clear_sticky) begin
            m_sc = 0; m_sv = 0; m_cnt = 0;
         end
      end
   end

   // Output side: every presented entry must be the oldest outstanding one.
   always @(negedge clk) begin
      #2;
      if (rst_n && out_valid) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_out", int'({out_result, out_flags}), 0);
            if (out_result == 4'd0 && out_flags == 4'd0) begin
               bad++;
               $display("FAIL unexpected_out: output valid with empty scoreboard");
            end
         end else begin
            chk("out_result", int'(out_result), int'(sb_q[0][7:4]));
            chk("out_flags", int'(out_flags), int'(sb_q[0][3:0]));
            if (out_ready) void'(sb_q.pop_front());
         end
      end
   end

   always @(negedge clk) if (rnd_ready) out_ready = 1'($urandom_range(0, 1));

   task automatic drive(input bit op, input bit [3:0] a, input bit [3:0] b);
      bit [7:0] e;
      e = model(op, a, b);
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
      in_result = e[7:4]; in_cb = e[1];
   endtask

   // Present one op and hold it until accepted; returns at the negedge after
   // the accepting edge.
   task automatic send(input bit op, input bit [3:0] a, input bit [3:0] b, input bit clr);
      bit acc;
      int n;
      drive(op, a, b);
      clear_sticky = clr;
      acc = 0; n = 0;
      while (!acc && n < 100) begin
         #1; acc = in_ready;
         @(negedge clk);
         n++;
      end
      if (!acc) begin
         bad++;
         $display("FAIL send_timeout: op not accepted within %0d cycles", n);
      end
      in_valid = 1'b0; clear_sticky = 1'b0;
   endtask

   task automatic drain();
      int n;
      out_ready = 1'b1; n = 0;
      while ((sb_q.size() != 0 || out_valid) && n < 200) begin @(negedge clk); n++; end
      chk("drain_done", sb_q.size(), 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_result", int'(out_result), 0);
      chk("rst_out_flags", int'(out_flags), 0);
      chk("rst_count", int'(op_count), 0);

      // directed flag cases
      out_ready = 1'b1;
      send(1, 4'd7, 4'd3, 0);
      chk("sub73_result", int'(out_result), 4);
      chk("sub73_flags", int'(out_flags), 4'b0000);
      chk("sub73_count", int'(op_count), 1);
      send(1, 4'd3, 4'd5, 0);
      chk("sub35_result", int'(out_result), 4'he);
      chk("sub35_flags", int'(out_flags), 4'b1010);
      chk("sub35_sticky_c", int'(sticky_c), 1);
      send(0, 4'd7, 4'd1, 0);
      chk("add71_result", int'(out_result), 8);
      chk("add71_flags", int'(out_flags), 4'b1001);
      send(1, 4'd5, 4'd5, 0);
      chk("sub55_flags", int'(out_flags), 4'b0100);
      chk("pre_clr_sticky_v", int'(sticky_v), 1);

      // clear colliding with an accept of C=1, V=0
      send(1, 4'd3, 4'd5, 1);
      chk("clr_col_sticky_c", int'(sticky_c), 1);
      chk("clr_col_sticky_v", int'(sticky_v), 0);
      chk("clr_col_count", int'(op_count), 1);
      drain();

      // clear alone
      clear_sticky = 1'b1; @(negedge clk); clear_sticky = 1'b0;
      chk("clr_count", int'(op_count), 0);
      chk("clr_sticky_c", int'(sticky_c), 0);

      // backpressure: 1, 2 accepted, 3 held until space frees
      out_ready = 1'b0;
      drive(0, 4'd1, 4'd0); @(negedge clk);
      chk("bp_ready_after1", int'(in_ready), 1);
      drive(0, 4'd2, 4'd0); @(negedge clk);
      chk("bp_ready_after2", int'(in_ready), 0);
      chk("bp_hold1", int'(out_result), 1);
      drive(0, 4'd3, 4'd0); @(negedge clk);
      chk("bp_ready_hold", int'(in_ready), 0);
      @(negedge clk);
      chk("bp_valid_hold", int'(out_valid), 1);
      chk("bp_result_hold", int'(out_result), 1);
      chk("bp_count2", int'(op_count), 2);
      out_ready = 1'b1; @(negedge clk);
      chk("bp_out2", int'(out_result), 2);
      chk("bp_ready_back", int'(in_ready), 1);
      @(negedge clk); in_valid = 1'b0;
      chk("bp_out3", int'(out_result), 3);
      chk("bp_valid3", int'(out_valid), 1);
      chk("bp_count3", int'(op_count), 3);
      @(negedge clk);
      chk("bp_empty", int'(out_valid), 0);

      // saturation
      for (int i = 0; i < 300; i++) send(0, 4'($urandom), 4'($urandom), 0);
      chk("sat_count", int'(op_count), 255);
      drain();

      // randomized traffic with random backpressure and occasional clears
      rnd_ready = 1;
      for (int i = 0; i < 400; i++)
         send(1'($urandom), 4'($urandom), 4'($urandom), ($urandom_range(0, 19) == 0));
      rnd_ready = 0;
      @(negedge clk);
      drain();

      // reset with both entries full
      out_ready = 1'b0;
      send(0, 4'd4, 4'd4, 0);
      send(0, 4'd5, 4'd1, 0);
      chk("pre_rst_full", int'(in_ready), 0);
      rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
      chk("mid_rst_valid", int'(out_valid), 0);
      chk("mid_rst_ready", int'(in_ready), 1);
      chk("mid_rst_count", int'(op_count), 0);
      chk("mid_rst_sticky_c", int'(sticky_c), 0);
      chk("mid_rst_sticky_v", int'(sticky_v), 0);
      chk("mid_rst_result", int'(out_result), 0);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_no_stale", int'(out_valid), 0);
      end
      send(0, 4'd2, 4'd3, 0);
      chk("post_rst_first", int'(out_result), 5);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/registro_resultado_bk.md
Name: registro_resultado_bk

Overview:
- Registered output stage placed directly downstream of the 4-bit Brent-Kung adder/subtractor.
- Captures the adder/subtractor result together with the operands and the carry/borrow bit, and derives the N, Z, C and V flags.
- Buffers results through a 2-entry valid/ready skid buffer so that backpressure from the consumer never loses or duplicates a result.
- Keeps sticky carry/overflow flags and a saturating count of accepted operations for the ALU status register.

Parameters:
- WIDTH, 4, datapath width of operands and result.
- CNT_W, 8, width of the accepted-operation counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  upstream result is valid this cycle.
- in_ready  output  1  block can accept an input this cycle.
- in_op  input  1  operation: 0 = add, 1 = subtract.
- in_a  input  WIDTH  operand a as applied to the adder/subtractor.
- in_b  input  WIDTH  operand b as applied to the adder/subtractor (uncomplemented).
- in_result  input  WIDTH  adder/subtractor sum or difference.
- in_cb  input  1  carry-out for add; borrow (inverted carry) for subtract.
- clear_sticky  input  1  clears sticky flags and the counter.
- out_valid  output  1  output entry valid.
- out_ready  input  1  downstream accepts the output this cycle.
- out_result  output  WIDTH  buffered result.
- out_flags  output  4  {N,Z,C,V} for out_result.
- sticky_c  output  1  OR of C over all accepted ops since the last clear.
- sticky_v  output  1  OR of V over all accepted ops since the last clear.
- op_count  output  CNT_W  number of accepted ops, saturating.

Behaviour:
- Flag computation, from the input fields and combinational at acceptance:
  - N = in_result[WIDTH-1].
  - Z = (in_result == 0).
  - C = in_cb, passed through unchanged for both ops.
  - V for add (in_op=0) = (a_msb == b_msb) && (r_msb != a_msb).
  - V for subtract (in_op=1) = (a_msb != b_msb) && (r_msb != a_msb).
- Storage: main register (drives the out_* ports) and skid register, each holding {result, flags} plus a valid bit.
- Accept = in_valid && in_ready. Pop = out_valid && out_ready.
- in_ready is registered and equals !skid_valid.
- Latency: an accepted input appears on the out_* ports the next cycle when the main register is empty or popping; otherwise the next cycle after it moves out of the skid register.
- Update rules, evaluated per cycle:
  - Main empty, or popping with the skid register empty: an accepted input is loaded into main.
  - Main full, not popping, input accepted: the input is loaded into skid, and in_ready drops the next cycle.
  - Popping with skid full: skid moves into main and skid becomes empty. No accept is possible in this cycle because in_ready = 0.
  - Popping with no accept and skid empty: out_valid goes to 0 the next cycle.
- Ordering is strict FIFO. No entry is dropped or duplicated. Output fields hold stable while out_valid && !out_ready.
- Sticky and counter:
  - On accept: sticky_c |= C, sticky_v |= V, and op_count increments, saturating at 2^CNT_W-1.
  - If clear_sticky and accept occur in the same cycle: sticky_c = C and sticky_v = V of the accepted input, and op_count = 1.
  - clear_sticky alone: all three are cleared to 0.
- Reset (rst_n low at a clock edge):
  - out_valid=0, skid_valid=0, in_ready=1, out_result=0, out_flags=0, sticky_c=0, sticky_v=0, op_count=0.
  - A reset mid-stream discards both buffered entries, and no pop occurs in the reset cycle.
  - The first accept can occur in the cycle after rst_n returns high.
- in_valid is ignored while in_ready=0. Upstream must hold its data until it is accepted.

Test Plan:
- Subtract 7-3: in_a=7, in_b=3, in_result=4, in_cb=0, op=1, out_ready=1 → next cycle out_result=4, out_flags=0000, op_count=1.
- Subtract 3-5: in_result=0xE, in_cb=1 → out_flags N=1, Z=0, C=1, V=0; sticky_c=1.
- Add 7+1: in_result=8, in_cb=0, op=0 → out_flags N=1, Z=0, C=0, V=1; also a subtract 5-5 with result=0 → Z=1 only.
- Backpressure:
  - Stimulus: out_ready=0, present results 1, 2, 3 back to back.
  - Acceptance: 1 and 2 are accepted; in_ready=0 from the cycle after 2 is accepted, and 3 is held.
  - Release: raise out_ready → outputs 1, 2, 3 in order with no gaps beyond one cycle; op_count=3.
- Clear collision: sticky_v=1; assert clear_sticky in the same cycle as accepting an op with C=1, V=0 → sticky_c=1, sticky_v=0, op_count=1. Separately, 300 accepts → op_count=255.
- Reset mid-operation: both entries full, assert rst_n=0 for one cycle → out_valid=0, in_ready=1, counters and sticky flags 0, and no stale output after reset.
